// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//   Time-multiplexes one shared active-low 7-segment bus across NUM_DIGITS
//   common-anode digits. Each digit shows one hex nibble of a packed value.
//   A blanking gap precedes every digit to stop ghosting. New values only
//   reach the display at frame boundaries, so a frame never tears.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset, released synchronously
//   value        packed hex digits, digit i = value[4i+3:4i]
//   value_valid  one-cycle load strobe for value and dp_mask
//   dp_mask      1 = light the decimal point on digit i
//   lz_blank     1 = blank leading zeros (sampled live)
//   seg          active-low segments {G,F,E,D,C,B,A}
//   dp           active-low decimal point
//   digit_en     active-low digit enables, at most one low
//   frame_done   one-cycle pulse during the last cycle of the last digit
//
// State table
//   state    | meaning
//   ST_BLANK | all digits off for BLANK_CYCLES cycles ahead of digit idx
//   ST_DRIVE | digit idx enabled for DWELL_CYCLES cycles with its segments

module seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    value_valid,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int MAX_PHASE = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW        = $clog2(MAX_PHASE + 1);
  localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_done_q, frame_done_d;

  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   lz_zero;
  logic                    zero_run;
  logic [3:0]              nib_sel;
  logic                    blank_sel;
  logic                    dp_sel;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + CW'(1);
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    frame_end  = 1'b0;

    if (value_valid) begin
      pend_val_d = value;
      pend_dp_d  = dp_mask;
    end

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d     = '0;
            frame_end = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
    endcase

    // A strobe landing on the boundary cycle goes straight to the display
    // rather than waiting a whole frame in the pending registers.
    if (frame_end) begin
      act_val_d = value_valid ? value   : pend_val_q;
      act_dp_d  = value_valid ? dp_mask : pend_dp_q;
    end

    // lz_zero[i] = nibbles NUM_DIGITS-1 down to i are all zero.
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (act_val_d[4*i +: 4] == 4'h0);
      lz_zero[i] = zero_run;
    end

    // Outputs are built from next-state values so enables and segments
    // switch together on one edge.
    nib_sel    = 4'h0;
    blank_sel  = 1'b0;
    dp_sel     = 1'b0;
    digit_en_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nib_sel   = act_val_d[4*i +: 4];
        blank_sel = lz_blank && (i != 0) && lz_zero[i];
        dp_sel    = act_dp_d[i];
        if (state_d == ST_DRIVE) begin
          digit_en_d[i] = 1'b0;
        end
      end
    end

    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (state_d == ST_DRIVE) begin
      seg_d = blank_sel ? 7'b1111111 : hex_to_seg(nib_sel);
      dp_d  = ~dp_sel;
    end

    frame_done_d = (state_d == ST_DRIVE) && (idx_d == IDX_LAST) && (cnt_d == DWELL_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      digit_en_q   <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
module tb_seg_scan_controller;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int P  = DW + BL;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        value_valid;
  logic [3:0]  dp_mask;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_en;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: absolute cycle count since reset release plus the
  // pending/shown value registers.
  int          t;
  logic [15:0] m_pend, m_act;
  logic [3:0]  m_pdp, m_adp;
  logic        m_lz_prev;
  logic        cur_lz;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg_scan_controller #(
    .NUM_DIGITS  (N),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .value_valid(value_valid),
    .dp_mask    (dp_mask),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .dp         (dp),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, exp_v);
    end
  endtask

  function automatic logic exp_fd(input int tt);
    return (((tt / P) % N) == N - 1) && ((tt % P) == P - 1);
  endfunction

  // Drive one cycle's inputs, compare outputs mid-cycle, advance the model.
  task automatic run_cycle(input logic [15:0] v, input logic vv, input logic [3:0] dpm, input logic lz);
    int         ph, d;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_en;
    logic       fd;
    logic [3:0] nib;
    value       = v;
    value_valid = vv;
    dp_mask     = dpm;
    lz_blank    = lz;
    ph    = t % P;
    d     = (t / P) % N;
    fd    = exp_fd(t);
    e_seg = 7'b1111111;
    e_dp  = 1'b1;
    e_en  = 4'hF;
    if (ph >= BL) begin
      e_en = ~(4'b0001 << d);
      nib  = 4'((m_act >> (4 * d)) & 16'hF);
      if (m_lz_prev && d != 0 && (m_act >> (4 * d)) == 16'h0) e_seg = 7'b1111111;
      else e_seg = seg_tab[nib];
      e_dp = ~m_adp[d];
    end
    @(negedge clk);
    check_eq("seg", 32'(seg), 32'(e_seg));
    check_eq("dp", 32'(dp), 32'(e_dp));
    check_eq("digit_en", 32'(digit_en), 32'(e_en));
    check_eq("frame_done", 32'(frame_done), 32'(fd));
    if (fd) begin
      m_act = vv ? v : m_pend;
      m_adp = vv ? dpm : m_pdp;
    end
    if (vv) begin
      m_pend = v;
      m_pdp  = dpm;
    end
    m_lz_prev = lz;
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      run_cycle(16'($urandom), 1'b0, 4'($urandom), cur_lz);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dpm);
    run_cycle(v, 1'b1, dpm, cur_lz);
  endtask

  task automatic advance_to_fd();
    for (int k = 0; k < 2 * N * P; k++) begin
      if (exp_fd(t)) break;
      idle(1);
    end
  endtask

  task automatic advance_to_drive(input int dig);
    for (int k = 0; k < 2 * N * P; k++) begin
      if (((t / P) % N) == dig && (t % P) >= BL) break;
      idle(1);
    end
  endtask

  // Called #1 after a rising edge; checks async assertion, releases after
  // the next edge and restarts the model at cycle 0.
  task automatic do_reset();
    value_valid = 1'b0;
    rst_n       = 1'b0;
    #1;
    check_eq("rst_seg", 32'(seg), 32'h7F);
    check_eq("rst_dp", 32'(dp), 32'h1);
    check_eq("rst_digit_en", 32'(digit_en), 32'hF);
    check_eq("rst_frame_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    t         = 0;
    m_pend    = '0;
    m_act     = '0;
    m_pdp     = '0;
    m_adp     = '0;
    m_lz_prev = lz_blank;
  endtask

  initial begin
    rst_n       = 1'b1;
    value       = '0;
    value_valid = 1'b0;
    dp_mask     = '0;
    lz_blank    = 1'b0;
    cur_lz      = 1'b0;
    t           = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Scan order and timing
    load(16'h1234, 4'b0000);
    idle(2 * N * P - 1);

    // Tear-free update while digit 2 is showing
    advance_to_drive(2);
    load(16'hABCD, 4'b0000);
    idle(2 * N * P);

    // Strobe on the exact frame boundary cycle
    advance_to_fd();
    load(16'h000F, 4'b0000);
    idle(N * P + 4);

    // Leading-zero blanking
    cur_lz = 1'b1;
    load(16'h0000, 4'b0000);
    idle(2 * N * P);
    load(16'h0105, 4'b0000);
    idle(2 * N * P);
    cur_lz = 1'b0;

    // Decimal point on digit 2
    load(16'h5678, 4'b0100);
    idle(2 * N * P);

    // Every decode table entry through digit 0
    for (int n = 0; n < 16; n++) begin
      load(16'(n), 4'b0000);
      idle(2 * N * P - 1);
    end

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(39, 0) == 0) cur_lz = ~cur_lz;
      if ($urandom_range(5, 0) == 0) load(16'($urandom), 4'($urandom));
      else idle(1);
    end

    // Reset in the middle of a DRIVE phase
    load(16'h9E3C, 4'b1010);
    idle(N * P + 1);
    advance_to_drive(1);
    do_reset();
    idle(2 * N * P);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
